uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmit path among NUM_REQ packet sources (game logic, status reporter, debug echo). It sits between the requesters and the UART transmitter clocked from the baud-rate generator. It grants the transmitter for a whole packet, forwards bytes over a valid/ready handshake, and enforces a programmable idle gap between packets so the receiving side can delimit frames.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmit path: grants one requester for a
// whole packet, passes its bytes through, then holds off for an idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [NUM_REQ-1:0]    grant_next;
    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      last_grant_next;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_cnt_next;
    logic [IDX_W-1:0]      owner;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  last_xfer;

    // Encode the one-hot grant into an index and select that requester's byte.
    always_comb begin
        owner      = '0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner      = grant[i] ? IDX_W'(i) : owner;
            owner_data = grant[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : owner_data;
        end
    end

    // Rotating-priority search starting just above the previous owner.
    always_comb begin
        int  cand;
        logic hit;
        pick_found = 1'b0;
        pick_idx   = last_grant;
        cand       = 0;
        hit        = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand       = (int'(last_grant) + k) % NUM_REQ;
            hit        = !pick_found && req_valid[IDX_W'(cand)];
            pick_idx   = hit ? IDX_W'(cand) : pick_idx;
            pick_found = pick_found | hit;
        end
    end

    // Pass-through datapath; tx_ready never feeds tx_valid, req_valid never feeds req_ready.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state == SEND) begin
            tx_valid         = req_valid[owner];
            req_ready[owner] = tx_ready;
            if (req_valid[owner]) begin
                tx_data = owner_data;
            end else begin
                tx_data = '0;
            end
        end else begin
            tx_valid = 1'b0;
        end
    end

    assign last_xfer = tx_valid && tx_ready && req_last[owner];
    assign busy      = (state != IDLE);

    // Next-state logic for the IDLE/SEND/GAP sequencer.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        gap_cnt_next    = gap_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next      = SEND;
                    grant_next      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    last_grant_next = pick_idx;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    grant_next = '0;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_W'(GAP_CYCLES);
                    end
                end else begin
                    state_next = SEND;
                end
            end
            GAP: begin
                // Saturating countdown: the counter stops at zero rather than wrapping.
                gap_cnt_next = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
                if (gap_cnt <= GAP_W'(1)) begin
                    state_next = IDLE;
                end else begin
                    state_next = GAP;
                end
            end
            default: begin
                state_next   = IDLE;
                grant_next   = '0;
                gap_cnt_next = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gap_cnt    <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            gap_cnt    <= gap_cnt_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (2 requesters, 4-cycle gap):
// direct checks, a table of pass-through vectors and a transfer scoreboard.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        logic [1:0] v;
        logic [7:0] d1;
        logic [7:0] d0;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [1:0] exp_rr;
    } vec_t;
    vec_t vecs[11];

    uart_tx_arbiter #(
        .NUM_REQ   (2),
        .DATA_WIDTH(8),
        .GAP_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l, input logic r);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        sb_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            next();
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
        next();
    endtask

    function automatic logic [7:0] rr_byte(input int i, input int p, input int x);
        return 8'(8'h40 + i * 16 + p * 2 + x);
    endfunction

    task automatic push_rr(input int i, input int p);
        logic [1:0] g;
        g = (i == 0) ? 2'b01 : 2'b10;
        push(g, rr_byte(i, p, 0));
        push(g, rr_byte(i, p, 1));
    endtask

    // Every accepted byte must match the next scoreboard entry (owner and data).
    always @(negedge clk) begin : monitor
        sb_t e;
        if (mon_en && !rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_xfer: got grant %0h data %0h, expected no transfer", grant, tx_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", grant, e.g);
                check("sb_data", tx_data, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rr_idx[2];
        int rr_pkt[2];
        int rr_done;
        int rr_owner;
        logic [1:0] hs;

        //                 v      d1     d0     rdy   exp_v exp_d  exp_rr
        vecs[0]  = '{2'b10, 8'hC1, 8'h77, 1'b1, 1'b1, 8'hC1, 2'b10};
        vecs[1]  = '{2'b11, 8'hC2, 8'h77, 1'b0, 1'b1, 8'hC2, 2'b00};
        vecs[2]  = '{2'b11, 8'hC2, 8'h77, 1'b0, 1'b1, 8'hC2, 2'b00};
        vecs[3]  = '{2'b11, 8'hC2, 8'h77, 1'b0, 1'b1, 8'hC2, 2'b00};
        vecs[4]  = '{2'b11, 8'hC2, 8'h77, 1'b0, 1'b1, 8'hC2, 2'b00};
        vecs[5]  = '{2'b11, 8'hC2, 8'h77, 1'b0, 1'b1, 8'hC2, 2'b00};
        vecs[6]  = '{2'b11, 8'hC2, 8'h77, 1'b1, 1'b1, 8'hC2, 2'b10};
        vecs[7]  = '{2'b01, 8'hC3, 8'h77, 1'b1, 1'b0, 8'h00, 2'b10};
        vecs[8]  = '{2'b01, 8'hC3, 8'h77, 1'b1, 1'b0, 8'h00, 2'b10};
        vecs[9]  = '{2'b01, 8'hC3, 8'h77, 1'b1, 1'b0, 8'h00, 2'b10};
        vecs[10] = '{2'b11, 8'hC3, 8'h77, 1'b1, 1'b1, 8'hC3, 2'b10};

        // Power-on reset
        rst = 1'b1;
        drive(2'b00, 16'h0000, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("por_grant", grant, 2'b00);
        check("por_busy", busy, 1'b0);
        check("por_tx_valid", tx_valid, 1'b0);
        next();
        rst = 1'b0;

        // Random traffic, then asynchronous reset mid-flight
        for (int c = 0; c < 8; c++) begin
            drive(2'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
            next();
        end
        rst = 1'b1;
        #1;
        check("arst_grant", grant, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_req_ready", req_ready, 2'b00);
        drive(2'b01, 16'h0011, 2'b01, 1'b0);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("rel_grant_before", grant, 2'b00);
        next();
        mon_en = 1'b1;
        check("rel_grant_after", grant, 2'b01);
        check("rel_tx_valid", tx_valid, 1'b1);
        check("rel_tx_data", tx_data, 8'h11);
        check("rel_req_ready_stall", req_ready, 2'b00);
        push(2'b01, 8'h11);
        tx_ready = 1'b1;
        @(negedge clk);
        check("rel_req_ready", req_ready, 2'b01);
        next();
        req_valid = 2'b00;
        wait_idle();

        // Round-robin with both requesters streaming 2-byte packets
        rr_idx   = '{0, 0};
        rr_pkt   = '{0, 0};
        rr_done  = 0;
        rr_owner = 1;
        push_rr(1, 0);
        for (int c = 0; c < 200 && rr_done < 4; c++) begin
            for (int i = 0; i < 2; i++) begin
                req_data[i*8 +: 8] = rr_byte(i, rr_pkt[i], rr_idx[i]);
                req_last[i]        = (rr_idx[i] == 1);
            end
            req_valid = 2'b11;
            tx_ready  = 1'b1;
            @(negedge clk);
            hs = req_ready & req_valid;
            next();
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    if (rr_idx[i] == 1) begin
                        rr_idx[i] = 0;
                        rr_pkt[i]++;
                        rr_done++;
                        rr_owner = 1 - rr_owner;
                        if (rr_done < 4) push_rr(rr_owner, rr_pkt[rr_owner]);
                    end else begin
                        rr_idx[i] = 1;
                    end
                end
            end
        end
        check("rr_packets", rr_done, 4);
        req_valid = 2'b00;
        wait_idle();

        // Single packet from requester 1 with requester 0 pending; gap timing
        drive(2'b11, {8'h52, 8'hA0}, 2'b01, 1'b1);
        push(2'b10, 8'h52);
        next();
        @(negedge clk);
        check("pkt_grant", grant, 2'b10);
        check("pkt_data0", tx_data, 8'h52);
        check("pkt_req_ready", req_ready, 2'b10);
        next();
        drive(2'b11, {8'h50, 8'hA0}, 2'b01, 1'b1);
        push(2'b10, 8'h50);
        @(negedge clk);
        check("pkt_data1", tx_data, 8'h50);
        next();
        drive(2'b11, {8'h53, 8'hA0}, 2'b11, 1'b1);
        push(2'b10, 8'h53);
        @(negedge clk);
        check("pkt_data2", tx_data, 8'h53);
        next();
        drive(2'b01, {8'h00, 8'hA0}, 2'b01, 1'b1);
        push(2'b01, 8'hA0);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("gap_grant_%0d", k), grant, (k == 5) ? 2'b01 : 2'b00);
            if (k < 5) check($sformatf("gap_busy_%0d", k), busy, (k < 4) ? 1'b1 : 1'b0);
            if (k < 5) next();
        end
        next();
        req_valid = 2'b00;
        wait_idle();

        // Backpressure and bubble table while requester 1 owns the path
        drive(2'b10, {8'hC0, 8'h77}, 2'b00, 1'b0);
        next();
        for (int r = 0; r < 11; r++) begin
            drive(vecs[r].v, {vecs[r].d1, vecs[r].d0}, 2'b00, vecs[r].rdy);
            if (vecs[r].exp_v && vecs[r].rdy) push(2'b10, vecs[r].exp_d);
            @(negedge clk);
            check($sformatf("vec%0d_grant", r), grant, 2'b10);
            check($sformatf("vec%0d_tx_valid", r), tx_valid, vecs[r].exp_v);
            check($sformatf("vec%0d_tx_data", r), tx_data, vecs[r].exp_d);
            check($sformatf("vec%0d_req_ready", r), req_ready, vecs[r].exp_rr);
            next();
        end
        drive(2'b10, {8'hC4, 8'h77}, 2'b10, 1'b1);
        push(2'b10, 8'hC4);
        @(negedge clk);
        check("tbl_last_data", tx_data, 8'hC4);
        next();
        req_valid = 2'b00;
        wait_idle();

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
